pmesh_l1_agent: RTL and testbench

// Private-cache (L1) endpoint of the PMESH L2 coherence protocol; counterpart of the L2 home agent.

---
 rtl/pmesh_l1_agent_pkg.sv | 62 ++++++
 rtl/pmesh_l1_agent_if.sv | 57 +++++
 rtl/pmesh_msg_out_reg.sv | 27 ++
 rtl/pmesh_l1_agent.sv | 146 ++++++++++++++
 tb/tb_pmesh_l1_agent.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pmesh_l1_agent_pkg.sv
// Shared widths, message codes, state enums and message payload for the PMESH L1 agent.
package pmesh_l1_agent_pkg;

  localparam int unsigned TAG_W  = 26;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TYPE_W = 8;
  localparam int unsigned ID_W   = 6;

  localparam logic [TYPE_W-1:0] LOAD_REQ     = 8'h1F;
  localparam logic [TYPE_W-1:0] STORE_REQ    = 8'h02;
  localparam logic [TYPE_W-1:0] LOAD_FWD     = 8'h10;
  localparam logic [TYPE_W-1:0] STORE_FWD    = 8'h11;
  localparam logic [TYPE_W-1:0] INV_FWD      = 8'h12;
  localparam logic [TYPE_W-1:0] LOAD_FWDACK  = 8'h15;
  localparam logic [TYPE_W-1:0] STORE_FWDACK = 8'h16;
  localparam logic [TYPE_W-1:0] INV_FWDACK   = 8'h17;
  localparam logic [TYPE_W-1:0] DATA_ACK     = 8'h1D;

  typedef enum logic [1:0] {
    LINE_I = 2'd0,
    LINE_S = 2'd1,
    LINE_M = 2'd2
  } line_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_REQ,
    ST_WAIT_ACK,
    ST_SEND_FWDACK
  } fsm_state_e;

  typedef struct packed {
    logic [TYPE_W-1:0] mtype;
    logic [ID_W-1:0]   source;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } msg_t;

  localparam int unsigned MSG_W = $bits(msg_t);

  // True for the three L2-forwarded request types.
  function automatic logic is_fwd(input logic [TYPE_W-1:0] t);
    return (t == LOAD_FWD) || (t == STORE_FWD) || (t == INV_FWD);
  endfunction

  // Reply type paired with a forwarded request.
  function automatic logic [TYPE_W-1:0] fwd_ack_type(input logic [TYPE_W-1:0] t);
    case (t)
      LOAD_FWD:  return LOAD_FWDACK;
      STORE_FWD: return STORE_FWDACK;
      default:   return INV_FWDACK;
    endcase
  endfunction

  // Line state after a forwarded request hits the held line.
  function automatic line_state_e fwd_next_state(input line_state_e st,
                                                 input logic [TYPE_W-1:0] t);
    if (t == LOAD_FWD) return (st == LINE_M) ? LINE_S : st;
    return LINE_I;
  endfunction

endpackage

// File: rtl/pmesh_l1_agent_if.sv
// Core request/response plus msg1/msg2/msg3 channels of the L1 agent.
interface pmesh_l1_agent_if;
  import pmesh_l1_agent_pkg::*;

  logic              core_req_valid;
  logic              core_req_ready;
  logic              core_req_store;
  logic [TAG_W-1:0]  core_req_tag;
  logic [DATA_W-1:0] core_req_data;
  logic              core_resp_valid;
  logic [DATA_W-1:0] core_resp_data;

  logic              msg1_valid;
  logic              msg1_ready;
  logic [TYPE_W-1:0] msg1_type;
  logic [ID_W-1:0]   msg1_source;
  logic [TAG_W-1:0]  msg1_tag;
  logic [DATA_W-1:0] msg1_data;

  logic              msg2_valid;
  logic              msg2_ready;
  logic [TYPE_W-1:0] msg2_type;
  logic [ID_W-1:0]   msg2_dest;
  logic [TAG_W-1:0]  msg2_tag;
  logic [DATA_W-1:0] msg2_data;

  logic              msg3_valid;
  logic              msg3_ready;
  logic [TYPE_W-1:0] msg3_type;
  logic [ID_W-1:0]   msg3_source;
  logic [TAG_W-1:0]  msg3_tag;
  logic [DATA_W-1:0] msg3_data;

  // Agent side.
  modport slave (
    input  core_req_valid, core_req_store, core_req_tag, core_req_data,
    output core_req_ready, core_resp_valid, core_resp_data,
    output msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
    input  msg1_ready,
    input  msg2_valid, msg2_type, msg2_dest, msg2_tag, msg2_data,
    output msg2_ready,
    output msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
    input  msg3_ready
  );

  // Core and L2 side.
  modport master (
    output core_req_valid, core_req_store, core_req_tag, core_req_data,
    input  core_req_ready, core_resp_valid, core_resp_data,
    input  msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
    output msg1_ready,
    output msg2_valid, msg2_type, msg2_dest, msg2_tag, msg2_data,
    input  msg2_ready,
    input  msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
    output msg3_ready
  );
endinterface

// File: rtl/pmesh_msg_out_reg.sv
// Valid/ready holding register: payload stays stable until the handshake.
module pmesh_msg_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  // Capture on load, drop valid once the receiver takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pmesh_l1_agent.sv
// PMESH L1 endpoint: one cached line, core requests to L2, forwarded-request service.
module pmesh_l1_agent
  import pmesh_l1_agent_pkg::*;
#(
  parameter logic [ID_W-1:0] MY_ID = 6'd0
) (
  input logic             clk,
  input logic             rst,
  pmesh_l1_agent_if.slave bus
);

  fsm_state_e        state, next_state, ret_state;
  line_state_e       line_st;
  logic [TAG_W-1:0]  line_tag, req_tag;
  logic [DATA_W-1:0] line_data, req_data, resp_data;
  logic              req_store, resp_valid;
  logic              core_take, fwd_take, fill;
  logic              msg2_mine, fwd_in, ack_in, core_hit, fwd_hit;
  logic              core_ready, msg2_rdy, core_fire;
  logic              msg1_valid, msg3_valid;
  msg_t              msg1_in, msg3_in, msg1_q, msg3_q;

  assign msg2_mine  = bus.msg2_valid && (bus.msg2_dest == MY_ID);
  assign fwd_in     = msg2_mine && is_fwd(bus.msg2_type);
  assign ack_in     = msg2_mine && (bus.msg2_type == DATA_ACK) && (bus.msg2_tag == req_tag);
  assign core_hit   = (line_st != LINE_I) && (line_tag == bus.core_req_tag) &&
                      (!bus.core_req_store || (line_st == LINE_M));
  assign fwd_hit    = (line_st != LINE_I) && (line_tag == bus.msg2_tag);
  assign core_ready = !rst && (state == ST_IDLE) && !fwd_in;
  assign msg2_rdy   = !rst && ((state == ST_IDLE) || (state == ST_WAIT_ACK));
  assign core_fire  = bus.core_req_valid && core_ready;

  assign msg1_in = '{mtype:  bus.core_req_store ? STORE_REQ : LOAD_REQ,
                     source: MY_ID,
                     tag:    bus.core_req_tag,
                     data:   bus.core_req_store ? bus.core_req_data : DATA_W'(0)};
  assign msg3_in = '{mtype:  fwd_ack_type(bus.msg2_type),
                     source: MY_ID,
                     tag:    bus.msg2_tag,
                     data:   line_data};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state and per-cycle actions; forwarded requests win over the core.
  always_comb begin
    next_state = state;
    core_take  = 1'b0;
    fwd_take   = 1'b0;
    fill       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fwd_in) begin
          fwd_take   = 1'b1;
          next_state = ST_SEND_FWDACK;
        end else if (core_fire) begin
          core_take = 1'b1;
          if (!core_hit) next_state = ST_SEND_REQ;
        end
      end
      ST_SEND_REQ: if (msg1_valid && bus.msg1_ready) next_state = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (fwd_in) begin
          fwd_take   = 1'b1;
          next_state = ST_SEND_FWDACK;
        end else if (ack_in) begin
          fill       = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_SEND_FWDACK: if (msg3_valid && bus.msg3_ready) next_state = ret_state;
      default: next_state = ST_IDLE;
    endcase
  end

  // Line, captured request, return state and core response.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_st    <= LINE_I;
      line_tag   <= '0;
      line_data  <= '0;
      req_store  <= 1'b0;
      req_tag    <= '0;
      req_data   <= '0;
      ret_state  <= ST_IDLE;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (core_take) begin
        req_store <= bus.core_req_store;
        req_tag   <= bus.core_req_tag;
        req_data  <= bus.core_req_data;
        if (core_hit) begin
          resp_valid <= 1'b1;
          if (bus.core_req_store) begin
            line_data <= bus.core_req_data;
            resp_data <= bus.core_req_data;
          end else begin
            resp_data <= line_data;
          end
        end
      end
      if (fwd_take) begin
        ret_state <= state;
        if (fwd_hit) line_st <= fwd_next_state(line_st, bus.msg2_type);
      end
      if (fill) begin
        line_tag   <= req_tag;
        line_st    <= req_store ? LINE_M : LINE_S;
        line_data  <= req_store ? req_data : bus.msg2_data;
        resp_data  <= req_store ? req_data : bus.msg2_data;
        resp_valid <= 1'b1;
      end
    end
  end

  pmesh_msg_out_reg #(.W(MSG_W)) u_msg1 (
    .clk(clk), .rst(rst), .load(core_take && !core_hit), .din(msg1_in),
    .ready(bus.msg1_ready), .valid(msg1_valid), .dout(msg1_q)
  );

  pmesh_msg_out_reg #(.W(MSG_W)) u_msg3 (
    .clk(clk), .rst(rst), .load(fwd_take), .din(msg3_in),
    .ready(bus.msg3_ready), .valid(msg3_valid), .dout(msg3_q)
  );

  assign bus.core_req_ready  = core_ready;
  assign bus.msg2_ready      = msg2_rdy;
  assign bus.core_resp_valid = resp_valid;
  assign bus.core_resp_data  = resp_data;
  assign bus.msg1_valid      = msg1_valid;
  assign bus.msg1_type       = msg1_q.mtype;
  assign bus.msg1_source     = msg1_q.source;
  assign bus.msg1_tag        = msg1_q.tag;
  assign bus.msg1_data       = msg1_q.data;
  assign bus.msg3_valid      = msg3_valid;
  assign bus.msg3_type       = msg3_q.mtype;
  assign bus.msg3_source     = msg3_q.source;
  assign bus.msg3_tag        = msg3_q.tag;
  assign bus.msg3_data       = msg3_q.data;

endmodule

// File: tb/tb_pmesh_l1_agent.sv
// Directed bench for pmesh_l1_agent with a transaction-level line model.
module tb_pmesh_l1_agent;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pmesh_l1_agent_if bus ();

  pmesh_l1_agent #(.MY_ID(6'd0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Model: one line plus at most one outstanding request, expected outputs queued.
  logic [1:0]   m_st;
  logic [25:0]  m_tag, m_ptag;
  logic [63:0]  m_data, m_pdata, last_resp;
  logic         m_pend, m_pstore;
  logic [103:0] exp_msg1[$];
  logic [103:0] exp_msg3[$];
  logic [63:0]  exp_resp[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic void model_reset();
    m_st = 2'd0; m_tag = '0; m_data = '0;
    m_pend = 1'b0; m_pstore = 1'b0; m_ptag = '0; m_pdata = '0;
    exp_msg1.delete(); exp_msg3.delete(); exp_resp.delete();
  endfunction

  function automatic void model_core(input logic st, input logic [25:0] tag, input logic [63:0] data);
    if (m_st != 2'd0 && m_tag == tag && (!st || m_st == 2'd2)) begin
      if (st) m_data = data;
      exp_resp.push_back(m_data);
    end else begin
      exp_msg1.push_back({st ? 8'h02 : 8'h1F, 6'd0, tag, st ? data : 64'd0});
      m_pend = 1'b1; m_pstore = st; m_ptag = tag; m_pdata = data;
    end
  endfunction

  function automatic void model_msg2(input logic [7:0] t, input logic [5:0] dest,
                                     input logic [25:0] tag, input logic [63:0] data);
    if (dest != 6'd0) return;
    if (t == 8'h10 || t == 8'h11 || t == 8'h12) begin
      exp_msg3.push_back({t + 8'd5, 6'd0, tag, m_data});
      if (m_st != 2'd0 && m_tag == tag) begin
        if (t != 8'h10) m_st = 2'd0;
        else if (m_st == 2'd2) m_st = 2'd1;
      end
    end else if (t == 8'h1D && m_pend && tag == m_ptag) begin
      m_tag  = tag;
      m_st   = m_pstore ? 2'd2 : 2'd1;
      m_data = m_pstore ? m_pdata : data;
      m_pend = 1'b0;
      exp_resp.push_back(m_data);
    end
  endfunction

  // Compare DUT outputs against the model's expected transactions every cycle.
  always @(negedge clk) begin
    if (bus.msg1_valid === 1'b1) begin
      if (exp_msg1.size() == 0) check("msg1_unexpected", 1, 0);
      else begin
        check("msg1", {bus.msg1_type, bus.msg1_source, bus.msg1_tag, bus.msg1_data}, exp_msg1[0]);
        if (bus.msg1_ready) void'(exp_msg1.pop_front());
      end
    end
    if (bus.msg3_valid === 1'b1) begin
      if (exp_msg3.size() == 0) check("msg3_unexpected", 1, 0);
      else begin
        check("msg3", {bus.msg3_type, bus.msg3_source, bus.msg3_tag, bus.msg3_data}, exp_msg3[0]);
        if (bus.msg3_ready) void'(exp_msg3.pop_front());
      end
    end
    if (bus.core_resp_valid === 1'b1) begin
      if (exp_resp.size() == 0) check("resp_unexpected", 1, 0);
      else begin
        check("resp_data", bus.core_resp_data, exp_resp[0]);
        last_resp = exp_resp.pop_front();
      end
    end
    if (bus.msg1_valid === 1'b1 || bus.msg3_valid === 1'b1)
      check("busy_readies", {bus.msg2_ready, bus.core_req_ready}, 2'b00);
  end

  task automatic do_core(input logic st, input logic [25:0] tag, input logic [63:0] data);
    int n = 0;
    bus.core_req_valid = 1'b1; bus.core_req_store = st;
    bus.core_req_tag = tag; bus.core_req_data = data;
    do begin @(negedge clk); n++; end while (!bus.core_req_ready && n < 100);
    if (!bus.core_req_ready) timeout_fail("core_req");
    else model_core(st, tag, data);
    @(posedge clk); #1;
    bus.core_req_valid = 1'b0;
  endtask

  task automatic do_msg2(input logic [7:0] t, input logic [5:0] dest,
                         input logic [25:0] tag, input logic [63:0] data);
    int n = 0;
    bus.msg2_valid = 1'b1; bus.msg2_type = t; bus.msg2_dest = dest;
    bus.msg2_tag = tag; bus.msg2_data = data;
    do begin @(negedge clk); n++; end while (!bus.msg2_ready && n < 100);
    if (!bus.msg2_ready) timeout_fail("msg2");
    else model_msg2(t, dest, tag, data);
    @(posedge clk); #1;
    bus.msg2_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_msg1.size() != 0 || exp_msg3.size() != 0 || exp_resp.size() != 0) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) timeout_fail("quiet");
    @(posedge clk); #1;
  endtask

  task automatic check_line(input string name, input logic [1:0] lit);
    check({name, "_model"}, 128'(dut.line_st), 128'(m_st));
    check(name, 128'(dut.line_st), 128'(lit));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.core_req_valid = 1'b0; bus.core_req_store = 1'b0;
    bus.core_req_tag = '0; bus.core_req_data = '0;
    bus.msg1_ready = 1'b1; bus.msg3_ready = 1'b1;
    bus.msg2_valid = 1'b0; bus.msg2_type = '0; bus.msg2_dest = '0;
    bus.msg2_tag = '0; bus.msg2_data = '0;
    last_resp = '0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_valids", {bus.msg1_valid, bus.msg3_valid, bus.core_resp_valid}, 3'b000);
    check("rst_readies", {bus.core_req_ready, bus.msg2_ready}, 2'b00);
    check("rst_outputs", {bus.core_resp_data, bus.msg1_type, bus.msg3_tag}, '0);
    check_line("rst_line", 2'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #1;
    check("idle_readies", {bus.core_req_ready, bus.msg2_ready}, 2'b11);
    @(posedge clk); #1;

    // Load miss then fill.
    do_core(1'b0, 26'h0AB, 64'h0);
    do_msg2(8'h1D, 6'd0, 26'h0AB, 64'h1234);
    wait_quiet();
    check("load_fill_data", last_resp, 64'h1234);
    check_line("load_fill_line", 2'd1);

    // Upgrade store, then store hits.
    do_core(1'b1, 26'h0AB, 64'h55);
    do_msg2(8'h1D, 6'd0, 26'h0AB, 64'hDEAD);
    wait_quiet();
    check("upgrade_data", last_resp, 64'h55);
    check_line("upgrade_line", 2'd2);
    do_core(1'b1, 26'h0AB, 64'h99);
    check("hit_one_cycle", {bus.core_resp_valid, bus.msg1_valid}, 2'b10);
    do_core(1'b1, 26'h0AB, 64'h55);
    check("hit_one_cycle2", {bus.core_resp_valid, bus.core_resp_data}, {1'b1, 64'h55});
    wait_quiet();

    // Forwarded load then invalidate.
    do_msg2(8'h10, 6'd0, 26'h0AB, 64'h0);
    wait_quiet();
    check_line("load_fwd_line", 2'd1);
    do_msg2(8'h12, 6'd0, 26'h0AB, 64'h0);
    wait_quiet();
    check_line("inv_fwd_line", 2'd0);

    // msg1 back-pressure, then stray msg2 traffic while waiting.
    bus.msg1_ready = 1'b0;
    do_core(1'b0, 26'h123, 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_valid", bus.msg1_valid, 1'b1);
      check("stall_payload", {bus.msg1_type, bus.msg1_source, bus.msg1_tag, bus.msg1_data},
            {8'h1F, 6'd0, 26'h123, 64'h0});
      check("stall_msg2_ready", bus.msg2_ready, 1'b0);
    end
    @(posedge clk); #1; bus.msg1_ready = 1'b1;
    do_msg2(8'h1D, 6'd0, 26'h124, 64'h1);
    do_msg2(8'h1D, 6'd5, 26'h123, 64'h2);
    do_msg2(8'h33, 6'd0, 26'h123, 64'h3);
    do_msg2(8'h1D, 6'd0, 26'h123, 64'hCAFE);
    wait_quiet();
    check("stall_fill_data", last_resp, 64'hCAFE);
    check_line("stall_fill_line", 2'd1);

    // Forward arriving during an upgrade, then the fill.
    do_core(1'b1, 26'h123, 64'hBEEF);
    do_msg2(8'h11, 6'd0, 26'h123, 64'h0);
    do_msg2(8'h1D, 6'd0, 26'h123, 64'h1111);
    wait_quiet();
    check("fwd_then_fill_data", last_resp, 64'hBEEF);
    check_line("fwd_then_fill_line", 2'd2);

    // Forward to another tag, and one for another node.
    do_msg2(8'h10, 6'd0, 26'h007, 64'h0);
    do_msg2(8'h10, 6'd3, 26'h123, 64'h0);
    wait_quiet();
    check_line("fwd_miss_line", 2'd2);

    // Reset while a fwd-ack is held.
    bus.msg3_ready = 1'b0;
    do_msg2(8'h12, 6'd0, 26'h123, 64'h0);
    @(negedge clk); #1;
    check("fwdack_held", {bus.msg3_valid, bus.msg3_type, bus.msg3_data}, {1'b1, 8'h17, 64'hBEEF});
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("midrst_valids", {bus.msg1_valid, bus.msg3_valid, bus.core_resp_valid}, 3'b000);
    check("midrst_readies", {bus.core_req_ready, bus.msg2_ready}, 2'b00);
    check_line("midrst_line", 2'd0);
    @(posedge clk); #1; rst = 1'b0; bus.msg3_ready = 1'b1;
    @(negedge clk); #1;
    check("post_rst_ready", bus.core_req_ready, 1'b1);
    @(posedge clk); #1;
    do_core(1'b0, 26'h123, 64'h0);
    do_msg2(8'h1D, 6'd0, 26'h123, 64'h42);
    wait_quiet();
    check("post_rst_fill", last_resp, 64'h42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
